// File: rtl/spi_flash_target_pkg.sv
// Shared definitions for the SPI flash responder: opcodes, status bit
// positions, FSM state encoding and the JEDEC identification bytes.
package spi_flash_target_pkg;

  localparam logic [23:0] JEDEC_ID = 24'hEF4017;

  localparam logic [7:0] OP_WRSR      = 8'h01;
  localparam logic [7:0] OP_PP        = 8'h02;
  localparam logic [7:0] OP_READ      = 8'h03;
  localparam logic [7:0] OP_WRDI      = 8'h04;
  localparam logic [7:0] OP_RDSR      = 8'h05;
  localparam logic [7:0] OP_WREN      = 8'h06;
  localparam logic [7:0] OP_FAST_READ = 8'h0B;
  localparam logic [7:0] OP_RDID      = 8'h9F;
  localparam logic [7:0] OP_BE        = 8'hC7;
  localparam logic [7:0] OP_SE        = 8'hD8;

  localparam int STAT_WIP = 0;
  localparam int STAT_WEL = 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_OPCODE,
    ST_ADDR,
    ST_DUMMY,
    ST_DATA_IN,
    ST_DATA_OUT,
    ST_IGNORE
  } state_t;

  // RDID byte sequence: manufacturer, type, capacity, then zeros.
  function automatic logic [7:0] id_byte(input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = JEDEC_ID[23:16];
      2'd1:    b = JEDEC_ID[15:8];
      2'd2:    b = JEDEC_ID[7:0];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/spi_flash_target_if.sv
// Pin and backing-store bundle of the SPI flash responder. The slave modport
// is the responder's view; master is the SPI host / memory side.
interface spi_flash_target_if;
  logic        spi_cs;
  logic        spi_dclk;
  logic        spi_mosi;
  logic        spi_miso;
  logic [23:0] mem_addr;
  logic        mem_rd_req;
  logic [7:0]  mem_rd_data;
  logic        mem_wr_en;
  logic [7:0]  mem_wr_data;
  logic        erase_sector;
  logic        erase_chip;
  logic        busy;
  logic [7:0]  status;

  modport slave (
    input  spi_cs, spi_dclk, spi_mosi, mem_rd_data, busy,
    output spi_miso, mem_addr, mem_rd_req, mem_wr_en, mem_wr_data,
           erase_sector, erase_chip, status
  );

  modport master (
    output spi_cs, spi_dclk, spi_mosi, mem_rd_data, busy,
    input  spi_miso, mem_addr, mem_rd_req, mem_wr_en, mem_wr_data,
           erase_sector, erase_chip, status
  );
endinterface

// File: rtl/spi_flash_target_sync.sv
// Brings the asynchronous SPI pins into the clk domain and produces
// single-cycle edge pulses. Levels and pulses are aligned: both appear
// three clocks after the pin edge.
module spi_flash_target_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic cs,
  input  logic dclk,
  input  logic mosi,
  output logic cs_level,
  output logic cs_rise,
  output logic cs_fall,
  output logic dclk_rise,
  output logic dclk_fall,
  output logic mosi_level
);

  // [0],[1] are the metastability pair, [2] is the delayed copy for edges.
  logic [2:0] cs_sh;
  logic [2:0] dclk_sh;
  logic [2:0] mosi_sh;

  // Synchronizer chains and registered edge pulses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cs_sh     <= 3'b111;
      dclk_sh   <= 3'b000;
      mosi_sh   <= 3'b000;
      cs_rise   <= 1'b0;
      cs_fall   <= 1'b0;
      dclk_rise <= 1'b0;
      dclk_fall <= 1'b0;
    end else begin
      cs_sh     <= {cs_sh[1:0], cs};
      dclk_sh   <= {dclk_sh[1:0], dclk};
      mosi_sh   <= {mosi_sh[1:0], mosi};
      cs_rise   <= cs_sh[1] & ~cs_sh[2];
      cs_fall   <= ~cs_sh[1] & cs_sh[2];
      dclk_rise <= dclk_sh[1] & ~dclk_sh[2];
      dclk_fall <= ~dclk_sh[1] & dclk_sh[2];
    end
  end

  assign cs_level   = cs_sh[2];
  assign mosi_level = mosi_sh[2];

endmodule

// File: rtl/spi_flash_target.sv
// SPI mode-0 flash responder: decodes the flash command set from oversampled
// pins, drives MISO, talks to a byte-wide backing store and keeps BP/WEL.
module spi_flash_target
  import spi_flash_target_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  spi_flash_target_if.slave bus
);

  logic cs_level, cs_rise, cs_fall, dclk_rise, dclk_fall, mosi;

  spi_flash_target_sync u_sync (
    .clk        (clk),
    .rst_n      (rst_n),
    .cs         (bus.spi_cs),
    .dclk       (bus.spi_dclk),
    .mosi       (bus.spi_mosi),
    .cs_level   (cs_level),
    .cs_rise    (cs_rise),
    .cs_fall    (cs_fall),
    .dclk_rise  (dclk_rise),
    .dclk_fall  (dclk_fall),
    .mosi_level (mosi)
  );

  state_t      state;
  logic [2:0]  bit_cnt;
  logic [1:0]  addr_byte;
  logic [2:0]  byte_total;   // whole bytes this frame, saturating
  logic [7:0]  cmd;
  logic        cmd_valid;    // opcode decoded and not refused for busy
  logic        accepted;     // PP/WRSR actually allowed to modify state
  logic [6:0]  shift_in;
  logic [7:0]  shift_out;
  logic [1:0]  id_idx;
  logic        load_pending;
  logic [5:0]  bp;
  logic        wel;
  logic        miso;
  logic        rd_req;
  logic        wr_en;
  logic        erase_sector;
  logic        erase_chip;
  logic [23:0] addr;
  logic [7:0]  wr_data;
  logic [7:0]  status;
  logic [7:0]  status_next;
  logic [7:0]  rx_byte;

  assign rx_byte = {shift_in, mosi};

  // Status image: block-protect bits, write-enable latch, live busy flag.
  always_comb begin
    status_next           = {bp, 2'b00};
    status_next[STAT_WEL] = wel;
    status_next[STAT_WIP] = bus.busy;
  end

  // Command FSM, shifters, address/status registers and output strobes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      bit_cnt      <= 3'd0;
      addr_byte    <= 2'd0;
      byte_total   <= 3'd0;
      cmd          <= 8'h00;
      cmd_valid    <= 1'b0;
      accepted     <= 1'b0;
      shift_in     <= 7'd0;
      shift_out    <= 8'h00;
      id_idx       <= 2'd0;
      load_pending <= 1'b0;
      bp           <= 6'd0;
      wel          <= 1'b0;
      miso         <= 1'b0;
      rd_req       <= 1'b0;
      wr_en        <= 1'b0;
      erase_sector <= 1'b0;
      erase_chip   <= 1'b0;
      addr         <= 24'd0;
      wr_data      <= 8'h00;
      status       <= 8'h00;
    end else begin
      rd_req       <= 1'b0;
      wr_en        <= 1'b0;
      erase_sector <= 1'b0;
      erase_chip   <= 1'b0;
      status       <= status_next;
      // Backing store answers one clock after the request.
      load_pending <= rd_req;
      if (load_pending) shift_out <= bus.mem_rd_data;
      // Page-program address advances after the write strobe, inside the page.
      if (wr_en) addr[7:0] <= addr[7:0] + 8'd1;

      if (cs_level) begin
        state <= ST_IDLE;
        miso  <= 1'b0;
        if (cs_rise && cmd_valid) begin
          case (cmd)
            OP_WREN: wel <= 1'b1;
            OP_WRDI: wel <= 1'b0;
            OP_SE: begin
              if (wel && byte_total == 3'd4 && bit_cnt == 3'd0) begin
                erase_sector <= 1'b1;
                wel          <= 1'b0;
              end
            end
            OP_BE: begin
              if (wel && byte_total == 3'd1 && bit_cnt == 3'd0) begin
                erase_chip <= 1'b1;
                wel        <= 1'b0;
              end
            end
            OP_PP, OP_WRSR: if (accepted) wel <= 1'b0;
            default: ;
          endcase
          cmd_valid <= 1'b0;
        end
      end else if (state == ST_IDLE) begin
        if (cs_fall) begin
          state      <= ST_OPCODE;
          bit_cnt    <= 3'd0;
          byte_total <= 3'd0;
          addr_byte  <= 2'd0;
          cmd_valid  <= 1'b0;
          accepted   <= 1'b0;
          cmd        <= 8'h00;
        end
      end else begin
        if (dclk_fall && state == ST_DATA_OUT) begin
          miso      <= shift_out[7];
          shift_out <= {shift_out[6:0], 1'b0};
        end
        if (dclk_rise) begin
          shift_in <= rx_byte[6:0];
          bit_cnt  <= bit_cnt + 3'd1;
          if (state == ST_ADDR) addr <= {addr[22:0], mosi};
          if (bit_cnt == 3'd7) begin
            if (byte_total != 3'd7) byte_total <= byte_total + 3'd1;
            case (state)
              ST_OPCODE: begin
                cmd <= rx_byte;
                if (bus.busy && rx_byte != OP_RDSR) begin
                  state     <= ST_IGNORE;
                  cmd_valid <= 1'b0;
                end else begin
                  cmd_valid <= 1'b1;
                  case (rx_byte)
                    OP_WREN, OP_WRDI, OP_BE: state <= ST_IGNORE;
                    OP_RDSR: begin
                      state     <= ST_DATA_OUT;
                      shift_out <= status;
                    end
                    OP_RDID: begin
                      state     <= ST_DATA_OUT;
                      shift_out <= id_byte(2'd0);
                      id_idx    <= 2'd1;
                    end
                    OP_WRSR: state <= ST_DATA_IN;
                    OP_READ, OP_FAST_READ, OP_SE: state <= ST_ADDR;
                    OP_PP: begin
                      state    <= ST_ADDR;
                      accepted <= wel;
                    end
                    default: begin
                      state     <= ST_IGNORE;
                      cmd_valid <= 1'b0;
                    end
                  endcase
                end
              end
              ST_ADDR: begin
                addr_byte <= addr_byte + 2'd1;
                if (addr_byte == 2'd2) begin
                  case (cmd)
                    OP_READ: begin
                      state  <= ST_DATA_OUT;
                      rd_req <= 1'b1;
                    end
                    OP_FAST_READ: state <= ST_DUMMY;
                    OP_PP:        state <= ST_DATA_IN;
                    default:      state <= ST_IGNORE;
                  endcase
                end
              end
              ST_DUMMY: begin
                state  <= ST_DATA_OUT;
                rd_req <= 1'b1;
              end
              ST_DATA_IN: begin
                if (cmd == OP_PP) begin
                  if (accepted) begin
                    wr_en   <= 1'b1;
                    wr_data <= rx_byte;
                  end
                end else if (byte_total == 3'd1 && wel) begin
                  bp       <= rx_byte[7:2];
                  accepted <= 1'b1;
                end
              end
              ST_DATA_OUT: begin
                case (cmd)
                  OP_RDSR: shift_out <= status;
                  OP_RDID: begin
                    shift_out <= id_byte(id_idx);
                    if (id_idx != 2'd3) id_idx <= id_idx + 2'd1;
                  end
                  default: begin
                    addr   <= addr + 24'd1;
                    rd_req <= 1'b1;
                  end
                endcase
              end
              default: ;
            endcase
          end
        end
      end
    end
  end

  assign bus.spi_miso     = miso;
  assign bus.mem_addr     = addr;
  assign bus.mem_rd_req   = rd_req;
  assign bus.mem_wr_en    = wr_en;
  assign bus.mem_wr_data  = wr_data;
  assign bus.erase_sector = erase_sector;
  assign bus.erase_chip   = erase_chip;
  assign bus.status       = status;

endmodule
